robertsons_sequencer: RTL and testbench

ROBERTSONS_SEQUENCER -- requirements
Module: robertsons_sequencer

---
 rtl/robertsons_pkg.sv | 7 +
 rtl/robertsons_sequencer_fifo.sv | 31 +++
 rtl/robertsons_sequencer.sv | 90 +++++++++
 tb/tb_robertsons_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/robertsons_pkg.sv
// robertsons_pkg: shared widths, range limit and FSM state encoding for the sequencer
package robertsons_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  localparam logic signed [OP_W-1:0] MULTIPLICAND_MIN = -8'sd64;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, GUARD = 2'd2, WAIT = 2'd3} state_e;
endpackage

// File: rtl/robertsons_sequencer_fifo.sv
// op_fifo: operand-pair queue with show-ahead head and wrap-bit full/empty detection
module op_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign data_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/robertsons_sequencer.sv
// robertsons_sequencer: queues operand pairs, drives one multiply at a time, and
// registers each product (or a range/timeout error) for a ready/valid consumer.
module robertsons_sequencer
  import robertsons_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_multiplier,
  input  logic [OP_W-1:0]   in_multiplicand,
  output logic              mult_start,
  output logic [OP_W-1:0]   mult_multiplier,
  output logic [OP_W-1:0]   mult_multiplicand,
  input  logic              mult_done,
  input  logic [PROD_W-1:0] mult_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              out_error,
  output logic [15:0]       op_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [OP_W-1:0] mplier_q, mcand_q;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic valid_q, valid_d, err_q, err_d;
  logic [15:0] cnt_q;
  logic [2*OP_W-1:0] head;
  logic full, empty, push, pop, range_err, tmo_hit, wait_done, wait_tmo, wr_res;
  op_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*OP_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({in_multiplier, in_multiplicand}),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  assign in_ready = !full;
  assign push = in_valid && !full;
  // a pop needs somewhere to put its result, so it waits for the output slot to free
  assign pop = state_q == IDLE && !empty && (!valid_q || out_ready);
  assign range_err = $signed(head[OP_W-1:0]) < MULTIPLICAND_MIN;
  assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
  assign wait_done = state_q == WAIT && mult_done;
  assign wait_tmo = state_q == WAIT && !mult_done && tmo_hit;
  assign wr_res = (pop && range_err) || wait_done || wait_tmo;
  always_comb begin
    state_d = state_q == IDLE  ? (pop && !range_err ? START : IDLE) :
              state_q == START ? GUARD :
              state_q == GUARD ? WAIT :
              (mult_done || tmo_hit) ? IDLE : WAIT;
    tmo_d = state_q == WAIT ? tmo_q + 1'b1 : '0;
    valid_d = wr_res ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
    prod_d = wr_res ? (wait_done ? mult_product : '0) : prod_q;
    err_d = wr_res ? !wait_done : err_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      prod_q  <= prod_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_q + 16'(wr_res);
      if (pop) {mplier_q, mcand_q} <= head;
    end
  assign mult_start = state_q == START;
  assign mult_multiplier = mplier_q;
  assign mult_multiplicand = mcand_q;
  assign out_valid = valid_q;
  assign out_product = prod_q;
  assign out_error = err_q;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_robertsons_sequencer.sv
// tb_robertsons_sequencer: directed checks of the sequencer against a small multiplier stub
module tb_robertsons_sequencer;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1, mult_done = 0, stub_en = 1;
  logic [7:0] in_multiplier = 0, in_multiplicand = 0, mult_multiplier, mult_multiplicand;
  logic [15:0] mult_product = 0, out_product, op_count;
  logic in_ready, mult_start, out_valid, out_error;
  logic [1:0] scnt = 0;
  logic [16:0] res_q[$];
  int errors = 0, checks = 0, starts = 0, s0, k;

  robertsons_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_multiplier(in_multiplier), .in_multiplicand(in_multiplicand),
    .mult_start(mult_start), .mult_multiplier(mult_multiplier),
    .mult_multiplicand(mult_multiplicand), .mult_done(mult_done),
    .mult_product(mult_product), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_error(out_error), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // multiplier stub: done three edges after start, held high until the next start
  always @(posedge clk) begin
    if (mult_start) begin
      scnt <= 2'd3;
      mult_done <= 1'b0;
    end else if (scnt != 0) begin
      scnt <= scnt - 1'b1;
      if (scnt == 1 && stub_en) begin
        mult_done <= 1'b1;
        mult_product <= $signed(mult_multiplier) * $signed(mult_multiplicand);
      end
    end
  end

  always @(posedge clk) if (mult_start) starts++;
  always @(negedge clk) if (!reset && out_valid && out_ready) res_q.push_back({out_error, out_product});

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_multiplier = a;
    in_multiplicand = b;
    in_valid = 1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic get_result(input string tag, input logic [15:0] ep, input logic ee);
    int n = 0;
    logic [16:0] r;
    while (res_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    assert (res_q.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed no result expected one within 200 cycles", tag);
    end
    if (res_q.size() != 0) begin
      r = res_q.pop_front();
      chk({tag, "_product"}, r[15:0], ep);
      chk({tag, "_error"}, 16'(r[16]), 16'(ee));
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!mult_start && n < 100) begin @(negedge clk); n++; end
    chk("start_seen", 16'(mult_start), 16'd1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_product", out_product, 16'd0);
    chk("rst_op_count", op_count, 16'd0);
    chk("rst_mult_start", 16'(mult_start), 16'd0);
    reset = 0;
    @(posedge clk); #1;
    // single multiply and start latency
    push(8'd5, 8'd6);
    @(negedge clk);
    chk("lat_no_start_yet", 16'(mult_start), 16'd0);
    @(negedge clk);
    chk("lat_start", 16'(mult_start), 16'd1);
    chk("lat_mplier", 16'(mult_multiplier), 16'd5);
    chk("lat_mcand", 16'(mult_multiplicand), 16'd6);
    get_result("p5x6", 16'd30, 1'b0);
    chk("p5x6_count", op_count, 16'd1);
    chk("p5x6_starts", 16'(starts), 16'd1);
    // back-to-back burst, in_ready must stay high below four entries
    chk("burst_rdy0", 16'(in_ready), 16'd1); push(8'd7, -8'sd5);
    chk("burst_rdy1", 16'(in_ready), 16'd1); push(-8'sd5, 8'd6);
    chk("burst_rdy2", 16'(in_ready), 16'd1); push(-8'sd7, 8'd8);
    chk("burst_rdy3", 16'(in_ready), 16'd1); push(-8'sd9, -8'sd4);
    get_result("b0", 16'(-35), 1'b0);
    get_result("b1", 16'(-30), 1'b0);
    get_result("b2", 16'(-56), 1'b0);
    get_result("b3", 16'd36, 1'b0);
    chk("burst_count", op_count, 16'd5);
    // backpressure holds the result and blocks the next start
    @(posedge clk); #1 out_ready = 0;
    s0 = starts;
    push(8'd2, 8'd3);
    push(8'd4, 8'd5);
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    chk("bp_valid", 16'(out_valid), 16'd1);
    chk("bp_product", out_product, 16'd6);
    repeat (20) @(negedge clk);
    chk("bp_hold_valid", 16'(out_valid), 16'd1);
    chk("bp_hold_product", out_product, 16'd6);
    chk("bp_no_start", 16'(starts), 16'(s0 + 1));
    @(posedge clk); #1 out_ready = 1;
    get_result("bp0", 16'd6, 1'b0);
    get_result("bp1", 16'd20, 1'b0);
    chk("bp_starts", 16'(starts), 16'(s0 + 2));
    chk("bp_count", op_count, 16'd7);
    // multiplicand range boundary
    s0 = starts;
    push(8'd3, -8'sd65);
    get_result("range_m65", 16'd0, 1'b1);
    chk("range_no_start", 16'(starts), 16'(s0));
    push(8'd3, -8'sd64);
    get_result("range_m64", 16'(-192), 1'b0);
    chk("range_count", op_count, 16'd9);
    // timeout: START, GUARD, then 32 WAIT cycles
    stub_en = 0;
    push(8'd4, 8'd4);
    wait_start();
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 100);
    chk("tmo_cycles", 16'(k), 16'd34);
    get_result("tmo", 16'd0, 1'b1);
    stub_en = 1;
    push(-8'sd3, 8'd7);
    get_result("after_tmo", 16'(-21), 1'b0);
    chk("tmo_count", op_count, 16'd11);
    // reset in WAIT with two pairs queued
    stub_en = 0;
    push(8'd1, 8'd1);
    wait_start();
    repeat (5) @(negedge clk);
    push(8'd2, 8'd2);
    push(8'd3, 8'd3);
    #2 reset = 1;
    #1;
    chk("mid_rst_in_ready", 16'(in_ready), 16'd1);
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_product", out_product, 16'd0);
    chk("mid_rst_error", 16'(out_error), 16'd0);
    chk("mid_rst_count", op_count, 16'd0);
    chk("mid_rst_start", 16'(mult_start), 16'd0);
    chk("mid_rst_mplier", 16'(mult_multiplier), 16'd0);
    chk("mid_rst_mcand", 16'(mult_multiplicand), 16'd0);
    s0 = starts;
    repeat (2) @(negedge clk);
    reset = 0;
    stub_en = 1;
    repeat (60) @(negedge clk);
    chk("post_rst_results", 16'(res_q.size()), 16'd0);
    chk("post_rst_valid", 16'(out_valid), 16'd0);
    chk("post_rst_count", op_count, 16'd0);
    chk("post_rst_starts", 16'(starts), 16'(s0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
